insn_prefetch_queue: RTL

//  Instruction prefetcher between the CPU fetch stage and the bus_master insn port.

---
 rtl/insn_prefetch_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/insn_prefetch_queue.sv
// Instruction prefetcher: walks sequential word addresses from a redirectable PC,
// issues one bus read at a time and buffers returned words with their PC in a FIFO.
module insn_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [29:0] RESET_PC = 30'd0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         redirect,
   input  logic [29:0]                  redirect_pc,
   output logic                         out_valid,
   output logic [31:0]                  out_insn,
   output logic [29:0]                  out_pc,
   input  logic                         out_pop,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [29:0]                  insn_addr,
   output logic                         insn_start,
   input  logic                         insn_ready,
   input  logic [31:0]                  insn_data_rd
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [29:0]        next_pc_q, next_pc_d;
   logic [29:0]        addr_q, addr_d;
   logic [LVL_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [61:0]        mem_q [DEPTH];
   logic [61:0]        mem_d [DEPTH];

   logic               full;
   logic               push;
   logic               pop_ok;

   assign full   = (count_q == LVL_W'(DEPTH));
   assign pop_ok = out_pop && (count_q != '0) && !redirect;

   always_comb begin
      state_d    = state_q;
      next_pc_d  = next_pc_q;
      addr_d     = addr_q;
      insn_start = 1'b0;
      push       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && !full && !redirect) begin
               insn_start = 1'b1;
               addr_d     = next_pc_q;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (insn_ready && !redirect) begin
               push      = 1'b1;
               next_pc_d = next_pc_q + 30'd1;
               state_d   = S_IDLE;
            end else if (redirect && insn_ready) begin
               state_d = S_IDLE;
            end else if (redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (insn_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (redirect) begin
         next_pc_d = redirect_pc;
      end
   end

   // The bus address is presented combinationally in the start cycle, then held.
   assign insn_addr = insn_start ? next_pc_q : addr_q;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {next_pc_q, insn_data_rd};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + LVL_W'(push) - LVL_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         next_pc_q <= RESET_PC;
         addr_q    <= '0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         next_pc_q <= next_pc_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign out_valid         = (count_q != '0);
   assign {out_pc, out_insn} = mem_q[rd_ptr_q];
   assign level             = count_q;

endmodule
